// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall sequencer: stall bit map,
// register address width and FSM state encodings.
package pipeline_stall_ctrl_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int STALL_BUS    = 5;
  localparam int CNT_W        = 3;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  // Whole-pipeline freeze, front-end hold, and front-end-plus-decode hold.
  localparam logic [STALL_BUS-1:0] STALL_NONE   = 5'b00000;
  localparam logic [STALL_BUS-1:0] STALL_ALL    = 5'b11111;
  localparam logic [STALL_BUS-1:0] STALL_FETCH  = 5'b00011;
  localparam logic [STALL_BUS-1:0] STALL_DECODE = 5'b00111;

  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/bus status going into the stall sequencer and the per-stage
// control coming back out. The core drives master; the sequencer is slave.
interface pipeline_stall_ctrl_if;
  import pipeline_stall_ctrl_pkg::*;

  logic                 id_valid;
  reg_addr_t            id_rs;
  reg_addr_t            id_rt;
  logic                 id_use_rs;
  logic                 id_use_rt;
  logic                 ex_load;
  reg_addr_t            ex_dest;
  logic                 rom_busy;
  logic                 ram_busy;
  logic                 flush_req;

  logic [STALL_BUS-1:0] stall;
  logic                 bubble_id;
  logic                 bubble_ex;
  logic                 flush;
  logic [31:0]          stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_load, ex_dest, rom_busy, ram_busy, flush_req,
    input  stall, bubble_id, bubble_ex, flush, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_load, ex_dest, rom_busy, ram_busy, flush_req,
    output stall, bubble_id, bubble_ex, flush, stall_cycles
  );

endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Purely combinational load-use comparator: flags a consumer that reads the
// destination of an in-flight load. Register 0 is hardwired and never hazards.
module pipeline_stall_ctrl_load_use_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic      ld_i,
  input  logic      valid_i,
  input  reg_addr_t rs_i,
  input  reg_addr_t rt_i,
  input  logic      use_rs_i,
  input  logic      use_rt_i,
  input  reg_addr_t dest_i,
  output logic      hz_o
);

  logic rsHit;
  logic rtHit;

  assign rsHit = use_rs_i && (rs_i == dest_i);
  assign rtHit = use_rt_i && (rt_i == dest_i);
  assign hz_o  = ld_i && valid_i && (dest_i != '0) && (rsHit || rtHit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/bubble/flush sequencer for the 5-stage core; also counts
// cycles in which the PC is held.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1
)
(
  input logic                 clk,
  input logic                 rst,
  pipeline_stall_ctrl_if.slave ctrl
);

  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_LATENCY - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam bit               LOAD_MULTI   = (LOAD_LATENCY > 1);
  localparam bit               FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [31:0]          stallCycles_q;
  logic                 loadHazard;
  logic [STALL_BUS-1:0] stallVec;
  logic                 bubbleId;
  logic                 bubbleEx;
  logic                 flushOut;

  pipeline_stall_ctrl_load_use_detect u_detect (
    .ld_i     (ctrl.ex_load),
    .valid_i  (ctrl.id_valid),
    .rs_i     (ctrl.id_rs),
    .rt_i     (ctrl.id_rt),
    .use_rs_i (ctrl.id_use_rs),
    .use_rt_i (ctrl.id_use_rt),
    .dest_i   (ctrl.ex_dest),
    .hz_o     (loadHazard)
  );

  // A pending flush squashes IF/ID even while a data stall freezes the pipe.
  always_comb begin
    stallVec = STALL_NONE;
    bubbleId = 1'b0;
    bubbleEx = 1'b0;
    flushOut = 1'b0;
    if (rst) begin
      stallVec = STALL_NONE;
    end else if (ctrl.flush_req || (state_q == ST_FLUSH)) begin
      flushOut = 1'b1;
      bubbleId = 1'b1;
      if (ctrl.ram_busy) stallVec = STALL_ALL;
    end else if (ctrl.ram_busy) begin
      stallVec = STALL_ALL;
    end else if (ctrl.rom_busy) begin
      stallVec = STALL_FETCH;
      bubbleId = 1'b1;
    end else if (loadHazard || (state_q == ST_LOAD_STALL)) begin
      stallVec = STALL_DECODE;
      bubbleEx = 1'b1;
    end
  end

  assign ctrl.stall        = stallVec;
  assign ctrl.bubble_id    = bubbleId;
  assign ctrl.bubble_ex    = bubbleEx;
  assign ctrl.flush        = flushOut;
  assign ctrl.stall_cycles = stallCycles_q;

  // The load-stall countdown only advances when the pipe actually moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ctrl.flush_req) begin
            if (FLUSH_MULTI) begin
              state_q <= ST_FLUSH;
              cnt_q   <= FLUSH_RELOAD;
            end
          end else if (loadHazard && !ctrl.ram_busy && LOAD_MULTI) begin
            state_q <= ST_LOAD_STALL;
            cnt_q   <= LOAD_RELOAD;
          end
        end
        ST_LOAD_STALL: begin
          if (ctrl.flush_req) begin
            if (FLUSH_MULTI) begin
              state_q <= ST_FLUSH;
              cnt_q   <= FLUSH_RELOAD;
            end else begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end
          end else if (!ctrl.ram_busy) begin
            if (cnt_q <= 3'd1) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (ctrl.flush_req) begin
            cnt_q <= FLUSH_RELOAD;
          end else if (cnt_q <= 3'd1) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles_q <= '0;
    end else if (stallVec[STALL_PC]) begin
      stallCycles_q <= stallCycles_q + 32'd1;
    end
  end

endmodule
